calc_sequencer: RTL

- Sequences the calculator datapath. Captures two unsigned operands and an opcode on a go request, then performs add/sub in one cycle or multiply with an iterative shift-add engine. Produces the same 8-bit result format the display path already consumes.
- Sits between the switch/button front end (debounced, synchronous go) and the seven-segment/LED output stage.
- Replaces the free-running combinational select with a busy/done handshake.

---
 rtl/calc_pkg.sv | 19 +
 rtl/calc_sequencer_shift_add_mult.sv | 58 +++++
 rtl/calc_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: opcodes, FSM state
// encoding and the helper that sizes the zero-pad field of add/sub results.
package calc_pkg;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_MUL     = 2'b10;
  localparam logic [1:0] OP_MUL_ALT = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ADDSUB = 2'd1;
  localparam logic [1:0] ST_MUL    = 2'd2;

  // Zero bits between the overflow flag and the (WIDTH+1)-bit sum.
  function automatic int pad_width(input int width);
    return width - 2;
  endfunction

endpackage

// File: rtl/calc_sequencer_shift_add_mult.sv
// Iterative unsigned multiplier: one shift-add step per clock, multiplier
// LSB first. Operands are loaded on the start edge and WIDTH steps follow.
// 'done' is high during the cycle whose closing edge performs the final
// step, and 'product' is the value the accumulator takes on that edge, so
// the owner can register the finished product on the same edge.
module shift_add_mult
  import calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic               running;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand_sh;
  logic [WIDTH-1:0]   mplier_sh;

  assign done    = running && (count == CW'(WIDTH - 1));
  assign product = acc + (mplier_sh[0] ? mcand_sh : '0);

  // Load operands on start, then add the shifted multiplicand for each set multiplier bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running   <= 1'b0;
      count     <= '0;
      acc       <= '0;
      mcand_sh  <= '0;
      mplier_sh <= '0;
    end else if (start) begin
      running   <= 1'b1;
      count     <= '0;
      acc       <= '0;
      mcand_sh  <= {{WIDTH{1'b0}}, mcand};
      mplier_sh <= mplier;
    end else if (running) begin
      acc       <= product;
      mcand_sh  <= mcand_sh << 1;
      mplier_sh <= mplier_sh >> 1;
      if (done) begin
        running <= 1'b0;
        count   <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: captures operands and opcode on a rising go, runs
// add/sub in one cycle or multiply through the shift-add engine, and
// presents a registered result with a busy/done handshake.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         op,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               done
);

  localparam int PAD = pad_width(WIDTH);

  logic               go_q;
  logic               go_rise;
  logic               is_mul_op;
  logic [1:0]         state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [1:0]         op_q;
  logic [WIDTH:0]     sum;
  logic               ovf;
  logic [2*WIDTH-1:0] addsub_word;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign go_rise   = go & ~go_q;
  assign is_mul_op = (op == OP_MUL) || (op == OP_MUL_ALT);
  // The multiplier loads straight from the inputs on the capture edge so
  // that its WIDTH steps finish exactly WIDTH edges later.
  assign mul_start = (state == ST_IDLE) && go_rise && is_mul_op;

  shift_add_mult #(
    .WIDTH(WIDTH)
  ) u_mult (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mul_start),
    .mcand  (a),
    .mplier (b),
    .product(mul_product),
    .done   (mul_done)
  );

  // Remember last cycle's go so a held-high request starts only one operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_q <= 1'b0;
    end else begin
      go_q <= go;
    end
  end

  // Form the add/sub result word: overflow flag on top, zero pad, then the (WIDTH+1)-bit sum.
  always_comb begin
    sum = '0;
    ovf = 1'b0;
    if (op_q == OP_SUB) begin
      sum = {1'b0, a_q} - {1'b0, b_q};
      ovf = (a_q < b_q);
    end else begin
      sum = {1'b0, a_q} + {1'b0, b_q};
      ovf = sum[WIDTH];
    end
    addsub_word = {ovf, {PAD{1'b0}}, sum};
  end

  // Sequencing FSM: capture in IDLE, finish add/sub next edge or wait for the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go_rise) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            busy  <= 1'b1;
            state <= is_mul_op ? ST_MUL : ST_ADDSUB;
          end
        end
        ST_ADDSUB: begin
          result <= addsub_word;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        ST_MUL: begin
          if (mul_done) begin
            result <= mul_product;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
